imem_boot_loader: RTL and testbench

//  Sequences program load into the 64x32 instruction memory.
//  - Accepts a byte stream over a valid/ready handshake.
//  - Packs 4 bytes little-endian into one 32-bit word and issues one write per word to the memory write port.
//  - Holds the CPU in stall until a complete, legal image is loaded.
//  - Sits between the host/UART byte source and the instruction memory; the fetch path reads the memory directly.

---
 rtl/imem_boot_pkg.sv | 16 +
 rtl/imem_boot_loader_if.sv | 30 +++
 rtl/imem_byte_packer.sv | 38 +++
 rtl/imem_boot_loader.sv | 144 ++++++++++++++
 tb/tb_imem_boot_loader.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_boot_pkg.sv
// Shared types and sizing constants for the instruction-memory boot loader.
// Imported by the loader top and its byte packer.
package imem_boot_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    RUN   = 2'd3
  } state_e;

  localparam int DEPTH_WORDS     = 64;
  localparam int BYTES_PER_WORD  = 4;
  localparam int WORD_ADDR_SHIFT = 2;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream handshake plus instruction-memory write port.
// The loader is the slave of the byte stream and drives the memory write side.
interface imem_boot_loader_if #(
  parameter int ADDR_W = 8
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;

  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  mem_we,
    input  mem_waddr,
    input  mem_wdata
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output mem_we,
    output mem_waddr,
    output mem_wdata
  );
endinterface

// File: rtl/imem_byte_packer.sv
// Collects stream bytes little-endian into a 32-bit word.
// o_word_full flags the handshake that completes the word.
module imem_byte_packer
  import imem_boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_accept,
  input  logic [7:0]  i_byte,
  output logic        o_word_full,
  output logic [31:0] o_word
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);

  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_lanes;

  // Clear beats accept so an aborted partial word never leaks into the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_lanes <= '0;
    end else if (i_clear) begin
      r_cnt   <= '0;
      r_lanes <= '0;
    end else if (i_accept) begin
      r_lanes[{r_cnt, 3'b000} +: 8] <= i_byte;
      r_cnt                         <= r_cnt + CNT_W'(1);
    end
  end

  assign o_word_full = i_accept && !i_clear &&
                       (r_cnt == CNT_W'(BYTES_PER_WORD - 1));
  assign o_word      = r_lanes;

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a byte stream into the instruction memory one packed word at a time
// and holds the CPU stalled until a complete image has been written.
module imem_boot_loader #(
  parameter int DEPTH_WORDS = imem_boot_pkg::DEPTH_WORDS,
  parameter int ADDR_W      = 8,
  parameter int LEN_W       = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load_start,
  input  logic [LEN_W-1:0] i_load_len,
  input  logic             i_load_abort,
  imem_boot_loader_if.slave bus,
  output logic             o_cpu_stall,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  import imem_boot_pkg::*;

  localparam int WCNT_W = $clog2(DEPTH_WORDS);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [LEN_W-1:0]  r_len;
  logic [WCNT_W-1:0] r_word_cnt;
  logic              r_done;
  logic              r_err;

  logic              w_done_nxt;
  logic              w_err_nxt;
  logic              w_len_load;
  logic              w_cnt_clr;
  logic              w_cnt_inc;
  logic              w_pk_clear;
  logic              w_accept;
  logic              w_word_full;
  logic [31:0]       w_word;
  logic              w_len_ok;
  logic              w_last;

  assign w_accept = bus.byte_valid && bus.byte_ready;
  assign w_len_ok = (i_load_len != '0) && (i_load_len <= LEN_W'(DEPTH_WORDS));
  assign w_last   = (LEN_W'(r_word_cnt) == (r_len - LEN_W'(1)));

  imem_byte_packer u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_pk_clear),
    .i_accept    (w_accept),
    .i_byte      (bus.byte_data),
    .o_word_full (w_word_full),
    .o_word      (w_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len      <= '0;
      r_word_cnt <= '0;
    end else begin
      if (w_len_load) r_len <= i_load_len;
      if (w_cnt_clr) begin
        r_word_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_word_cnt <= r_word_cnt + WCNT_W'(1);
      end
    end
  end

  // Abort is only honoured in LOAD/WRITE; in IDLE/RUN a start always wins.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = r_done;
    w_err_nxt   = r_err;
    w_len_load  = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_pk_clear  = 1'b0;
    case (r_state)
      IDLE, RUN: begin
        if (i_load_start) begin
          if (w_len_ok) begin
            w_state_nxt = LOAD;
            w_done_nxt  = 1'b0;
            w_err_nxt   = 1'b0;
            w_len_load  = 1'b1;
            w_cnt_clr   = 1'b1;
            w_pk_clear  = 1'b1;
          end else begin
            w_err_nxt   = 1'b1;
          end
        end
      end
      LOAD: begin
        if (i_load_abort) begin
          w_state_nxt = IDLE;
          w_err_nxt   = 1'b1;
          w_pk_clear  = 1'b1;
        end else if (w_word_full) begin
          w_state_nxt = WRITE;
        end
      end
      WRITE: begin
        w_pk_clear = 1'b1;
        if (i_load_abort) begin
          w_state_nxt = IDLE;
          w_err_nxt   = 1'b1;
        end else if (w_last) begin
          w_state_nxt = RUN;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = LOAD;
          w_cnt_inc   = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Address and data are held steady from registers; only the strobe marks the write.
  assign bus.byte_ready = (r_state == LOAD);
  assign bus.mem_we     = (r_state == WRITE);
  assign bus.mem_waddr  = ADDR_W'(r_word_cnt) << WORD_ADDR_SHIFT;
  assign bus.mem_wdata  = w_word;

  assign o_cpu_stall = (r_state != RUN);
  assign o_busy      = (r_state == LOAD) || (r_state == WRITE);
  assign o_done      = r_done;
  assign o_err       = r_err;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: directed and randomized loads compared with an
// image model built from the byte stream (word i = bytes 4i..4i+3, little-endian).
module tb_imem_boot_loader;

  logic       clk;
  logic       rst_n;
  logic       i_load_start;
  logic [6:0] i_load_len;
  logic       i_load_abort;
  logic       o_cpu_stall;
  logic       o_busy;
  logic       o_done;
  logic       o_err;

  imem_boot_loader_if #(.ADDR_W(8)) bus ();

  imem_boot_loader #(.DEPTH_WORDS(64), .ADDR_W(8), .LEN_W(7)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load_start (i_load_start),
    .i_load_len   (i_load_len),
    .i_load_abort (i_load_abort),
    .bus          (bus),
    .o_cpu_stall  (o_cpu_stall),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  int         n_checks = 0;
  int         n_errors = 0;
  wr_t        got_q[$];
  logic [7:0] tb_bytes[256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Write monitor: capture every strobe away from the active edge.
  always @(negedge clk) begin
    if (rst_n && bus.mem_we) begin
      got_q.push_back('{addr: bus.mem_waddr, data: bus.mem_wdata});
      check("ready_during_write", {31'd0, bus.byte_ready}, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_byte_ready"}, {31'd0, bus.byte_ready}, 32'd0);
    check({pfx, "_mem_we"},     {31'd0, bus.mem_we},     32'd0);
    check({pfx, "_mem_waddr"},  {24'd0, bus.mem_waddr},  32'd0);
    check({pfx, "_mem_wdata"},  bus.mem_wdata,           32'd0);
    check({pfx, "_cpu_stall"},  {31'd0, o_cpu_stall},    32'd1);
    check({pfx, "_busy"},       {31'd0, o_busy},         32'd0);
    check({pfx, "_done"},       {31'd0, o_done},         32'd0);
    check({pfx, "_err"},        {31'd0, o_err},          32'd0);
  endtask

  task automatic pulse_start(input int len);
    i_load_start = 1'b1;
    i_load_len   = 7'(len);
    tick();
    i_load_start = 1'b0;
  endtask

  task automatic fill_random(input int nbytes);
    for (int i = 0; i < nbytes; i++) tb_bytes[i] = 8'($urandom);
  endtask

  // Compare captured writes and final status against the image model.
  task automatic verify(input string pfx, input int n_words, input bit aborted);
    logic [31:0] exp_d;
    check({pfx, "_nwrites"}, got_q.size(), n_words);
    for (int i = 0; i < n_words && i < got_q.size(); i++) begin
      exp_d = {tb_bytes[4*i+3], tb_bytes[4*i+2], tb_bytes[4*i+1], tb_bytes[4*i]};
      check($sformatf("%s_waddr[%0d]", pfx, i), {24'd0, got_q[i].addr}, 32'(4 * i));
      check($sformatf("%s_wdata[%0d]", pfx, i), got_q[i].data, exp_d);
    end
    check({pfx, "_busy"},  {31'd0, o_busy},      32'd0);
    check({pfx, "_done"},  {31'd0, o_done},      aborted ? 32'd0 : 32'd1);
    check({pfx, "_err"},   {31'd0, o_err},       aborted ? 32'd1 : 32'd0);
    check({pfx, "_stall"}, {31'd0, o_cpu_stall}, aborted ? 32'd1 : 32'd0);
  endtask

  // mode: 0 valid held high, 1 valid toggling, 2 random valid.
  // abort_at: abort once this many bytes are accepted (-1 none).
  // glitch_at: raise a stray load_start when this many bytes are accepted (-1 none).
  task automatic do_load(input string pfx, input int len, input int mode,
                         input int abort_at, input int glitch_at);
    int  total, k, cyc, budget;
    bit  v, tog, aborted, glitched, acc;
    total    = len * 4;
    budget   = total * 6 + 50;
    k        = 0;
    cyc      = 0;
    tog      = 1'b1;
    aborted  = 1'b0;
    glitched = 1'b0;
    got_q.delete();
    pulse_start(len);
    while (k < total && !aborted && cyc < budget) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = tog;
        default: v = 1'($urandom_range(0, 1));
      endcase
      if (glitch_at == k && !glitched) begin
        i_load_start = 1'b1;
        i_load_len   = 7'd1;
        glitched     = 1'b1;
      end
      if (abort_at == k && bus.byte_ready) begin
        i_load_abort   = 1'b1;
        bus.byte_valid = 1'b0;
        tick();
        i_load_abort   = 1'b0;
        aborted        = 1'b1;
      end else begin
        bus.byte_valid = v;
        bus.byte_data  = tb_bytes[k];
        acc            = v && bus.byte_ready;
        tick();
        if (acc) k++;
      end
      i_load_start = 1'b0;
      tog = ~tog;
      cyc++;
    end
    bus.byte_valid = 1'b0;
    while (o_busy && cyc < budget) begin
      tick();
      cyc++;
    end
    if (cyc >= budget) check({pfx, "_timeout"}, 32'(cyc), 32'(budget - 1));
    tick();
    verify(pfx, aborted ? (abort_at / 4) : len, aborted);
  endtask

  initial begin
    int len, mode, ab, gl, cyc;
    rst_n          = 1'b0;
    i_load_start   = 1'b0;
    i_load_len     = '0;
    i_load_abort   = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Illegal lengths from IDLE
    pulse_start(0);
    check("len0_err",   {31'd0, o_err},          32'd1);
    check("len0_stall", {31'd0, o_cpu_stall},    32'd1);
    check("len0_ready", {31'd0, bus.byte_ready}, 32'd0);
    check("len0_busy",  {31'd0, o_busy},         32'd0);
    tick();
    check("len0_idle_ready", {31'd0, bus.byte_ready}, 32'd0);
    pulse_start(65);
    check("len65_err",   {31'd0, o_err},       32'd1);
    check("len65_stall", {31'd0, o_cpu_stall}, 32'd1);
    check("len65_busy",  {31'd0, o_busy},      32'd0);
    check("len65_done",  {31'd0, o_done},      32'd0);

    // Directed two-word image
    tb_bytes[0] = 8'h33; tb_bytes[1] = 8'h70; tb_bytes[2] = 8'h00; tb_bytes[3] = 8'h00;
    tb_bytes[4] = 8'h93; tb_bytes[5] = 8'h00; tb_bytes[6] = 8'h10; tb_bytes[7] = 8'h00;
    do_load("t1", 2, 0, -1, -1);
    if (got_q.size() == 2) begin
      check("t1_word0", got_q[0].data, 32'h00007033);
      check("t1_word1", got_q[1].data, 32'h00100093);
    end

    // Illegal length while in RUN: err only, CPU keeps running
    pulse_start(0);
    check("run_len0_err",   {31'd0, o_err},       32'd1);
    check("run_len0_done",  {31'd0, o_done},      32'd1);
    check("run_len0_stall", {31'd0, o_cpu_stall}, 32'd0);

    // Single word with gappy valid
    fill_random(4);
    do_load("t3", 1, 1, -1, -1);

    // Abort after two bytes of word 1, then a clean reload
    fill_random(12);
    do_load("t4a", 3, 0, 6, -1);
    fill_random(8);
    do_load("t4b", 2, 2, -1, -1);

    // Full-depth image
    fill_random(256);
    do_load("t5", 64, 0, -1, -1);
    if (got_q.size() == 64) check("t5_last_addr", {24'd0, got_q[63].addr}, 32'h000000FC);

    // Stray load_start mid-load
    fill_random(16);
    do_load("t6g", 4, 0, -1, 5);

    // Randomized loads
    for (int t = 0; t < 12; t++) begin
      len  = $urandom_range(1, 8);
      mode = $urandom_range(0, 2);
      ab   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len * 4 - 1) : -1;
      gl   = ($urandom_range(0, 1) == 0) ? $urandom_range(0, len * 4 - 1) : -1;
      fill_random(len * 4);
      do_load($sformatf("rnd%0d", t), len, mode, ab, gl);
    end

    // Async reset while the second word is being written
    for (int i = 0; i < 12; i++) tb_bytes[i] = 8'hA0 + 8'(i);
    got_q.delete();
    pulse_start(3);
    cyc = 0;
    bus.byte_valid = 1'b1;
    while (!(bus.mem_we && bus.mem_waddr == 8'd4) && cyc < 40) begin
      bus.byte_data = tb_bytes[cyc % 12];
      tick();
      cyc++;
    end
    bus.byte_valid = 1'b0;
    check("midwr_reached", {31'd0, bus.mem_we}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("midwr");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_stall", {31'd0, o_cpu_stall}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

endmodule
